// File: rtl/slicer_if.sv
`default_nettype none
// ============================================================================
// Module      : slicer_if
// Description : Symbol/decision bundle for the 4-PAM slicer. The err_out
//               member exists only when SLICER_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface slicer_if;
    logic               sym_en;
    logic signed [17:0] slicer_in;
    logic        [1:0]  slicer_out;
    logic               out_valid;
    logic signed [17:0] ref_level;
    logic               ref_valid;
`ifdef SLICER_ERR_EN
    logic signed [17:0] err_out;

    modport master (
        output sym_en, slicer_in,
        input  slicer_out, out_valid, ref_level, ref_valid, err_out
    );
    modport slave (
        input  sym_en, slicer_in,
        output slicer_out, out_valid, ref_level, ref_valid, err_out
    );
`else
    modport master (
        output sym_en, slicer_in,
        input  slicer_out, out_valid, ref_level, ref_valid
    );
    modport slave (
        input  sym_en, slicer_in,
        output slicer_out, out_valid, ref_level, ref_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/slicer.sv
`default_nettype none
// ============================================================================
// Module      : slicer
// Description : 4-PAM decision slicer with an adaptive reference level.
//               The reference is the mean of |x| over windows of 2**AVG_LOG2
//               symbols; decisions use thresholds at -ref, 0 and +ref.
//               Optional macro SLICER_ERR_EN adds a registered, saturated
//               decision-error output (err_out).
// Revision    : 1.0 - initial release
// ============================================================================
module slicer #(
    parameter int                 AVG_LOG2 = 12,
    parameter logic signed [17:0] REF_INIT = 18'sd32768
) (
    input  logic     clk,
    input  logic     reset,
    slicer_if.slave  bus
);

    localparam int                 c_ACC_W   = 18 + AVG_LOG2;
    localparam logic signed [17:0] c_IN_MIN  = -18'sd131072;
    localparam logic        [17:0] c_MAG_MAX = 18'd131071;

    localparam logic [0:0] c_ST_ACQUIRE = 1'b0;
    localparam logic [0:0] c_ST_TRACK   = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic [c_ACC_W-1:0]  r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic signed [17:0]  r_ref;
    logic [1:0]          r_out;
    logic                r_valid;

    logic [17:0]         w_mag;
    logic [c_ACC_W-1:0]  w_sum;
    logic [17:0]         w_avg;
    logic signed [17:0]  w_new_ref;
    logic                w_win_done;
    logic signed [18:0]  w_x;
    logic signed [18:0]  w_ref_pos;
    logic signed [18:0]  w_ref_neg;
    logic [1:0]          w_dec;

    // Saturating magnitude: the most negative code has no positive twin.
    always_comb begin
        w_mag = bus.slicer_in;
        if (bus.slicer_in == c_IN_MIN) begin
            w_mag = c_MAG_MAX;
        end else if (bus.slicer_in[17]) begin
            w_mag = -bus.slicer_in;
        end
    end

    // Window sum, the averaged level and the end-of-window strobe.
    always_comb begin
        w_sum      = r_acc + {{AVG_LOG2{1'b0}}, w_mag};
        w_avg      = w_sum[c_ACC_W-1:AVG_LOG2];
        // A zero level would collapse all three thresholds onto zero.
        w_new_ref  = (w_avg == 18'd0) ? 18'sd1 : $signed(w_avg);
        w_win_done = bus.sym_en && (r_cnt == {AVG_LOG2{1'b1}});
    end

    // Threshold decision against the reference currently in use.
    always_comb begin
        w_x       = {bus.slicer_in[17], bus.slicer_in};
        w_ref_pos = {r_ref[17], r_ref};
        w_ref_neg = -w_ref_pos;
        if (w_x < w_ref_neg) begin
            w_dec = 2'b00;
        end else if (w_x < 19'sd0) begin
            w_dec = 2'b01;
        end else if (w_x < w_ref_pos) begin
            w_dec = 2'b10;
        end else begin
            w_dec = 2'b11;
        end
    end

    // Acquisition state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_ACQUIRE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leave acquisition on the first completed window; tracking is sticky.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_ACQUIRE: if (w_win_done) w_state_next = c_ST_TRACK;
            c_ST_TRACK:   w_state_next = c_ST_TRACK;
            default:      w_state_next = c_ST_ACQUIRE;
        endcase
    end

    // Averaging datapath and registered decision; a reset sample is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ref   <= REF_INIT;
            r_out   <= 2'b00;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.sym_en;
            if (bus.sym_en) begin
                r_out <= w_dec;
                r_cnt <= r_cnt + 1'b1;
                if (w_win_done) begin
                    r_acc <= '0;
                    r_ref <= w_new_ref;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign bus.slicer_out = r_out;
    assign bus.out_valid  = r_valid;
    assign bus.ref_level  = r_ref;
    assign bus.ref_valid  = (r_state == c_ST_TRACK);

`ifdef SLICER_ERR_EN
    logic signed [19:0] w_ref20;
    logic signed [19:0] w_half;
    logic signed [19:0] w_lvl;
    logic signed [19:0] w_diff;
    logic signed [17:0] w_err_sat;
    logic signed [17:0] r_err;

    // Ideal level of the decided symbol (+-ref/2, +-1.5 ref) and the error.
    always_comb begin
        w_ref20 = {{2{r_ref[17]}}, r_ref};
        w_half  = w_ref20 >>> 1;
        case (w_dec)
            2'b00:   w_lvl = -(w_ref20 + w_half);
            2'b01:   w_lvl = -w_half;
            2'b10:   w_lvl = w_half;
            default: w_lvl = w_ref20 + w_half;
        endcase
        w_diff = {{2{bus.slicer_in[17]}}, bus.slicer_in} - w_lvl;
        if (w_diff > 20'sd131071) begin
            w_err_sat = 18'sd131071;
        end else if (w_diff < -20'sd131072) begin
            w_err_sat = -18'sd131072;
        end else begin
            w_err_sat = w_diff[17:0];
        end
    end

    // Error register updates together with the decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else if (bus.sym_en) begin
            r_err <= w_err_sat;
        end
    end

    assign bus.err_out = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slicer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_slicer
// Description : Self-checking bench for slicer (AVG_LOG2 = 2). Directed
//               literal cases plus randomized traffic against a window-list
//               reference model. Checks err_out when SLICER_ERR_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slicer;

    localparam int c_AVG_LOG2 = 2;
    localparam int c_WIN      = 1 << c_AVG_LOG2;
    localparam int c_REF_INIT = 32768;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    slicer_if bus ();

    slicer #(
        .AVG_LOG2 (c_AVG_LOG2),
        .REF_INIT (18'sd32768)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ref   = c_REF_INIT;
    bit m_refv  = 1'b0;
    int m_out   = 0;
    bit m_valid = 1'b0;
    int m_err   = 0;
    int win[$];
    bit chk_on  = 1'b0;

    function automatic int mag(int x);
        if (x == -131072) return 131071;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int decide(int x, int r);
        if (x < -r) return 0;
        if (x < 0)  return 1;
        if (x < r)  return 2;
        return 3;
    endfunction

    function automatic int level(int d, int r);
        int h;
        h = r / 2;
        case (d)
            0:       return -(r + h);
            1:       return -h;
            2:       return h;
            default: return r + h;
        endcase
    endfunction

    function automatic int sat18(int v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted sample is decided with the current level, then
    // appended to the window; a full window replaces the level by its mean.
    always @(posedge clk) begin
        int x;
        int d;
        int s;
        if (reset) begin
            m_ref   = c_REF_INIT;
            m_refv  = 1'b0;
            m_out   = 0;
            m_valid = 1'b0;
            m_err   = 0;
            win.delete();
            chk_on  = 1'b1;
        end else if (bus.sym_en) begin
            x       = int'(bus.slicer_in);
            d       = decide(x, m_ref);
            m_out   = d;
            m_valid = 1'b1;
            m_err   = sat18(x - level(d, m_ref));
            win.push_back(mag(x));
            if (win.size() == c_WIN) begin
                s = 0;
                foreach (win[k]) s += win[k];
                s = s / c_WIN;
                if (s == 0) s = 1;
                m_ref  = s;
                m_refv = 1'b1;
                win.delete();
            end
        end else begin
            m_valid = 1'b0;
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("slicer_out", int'(bus.slicer_out), m_out);
            check("out_valid",  int'(bus.out_valid),  int'(m_valid));
            check("ref_level",  int'(bus.ref_level),  m_ref);
            check("ref_valid",  int'(bus.ref_valid),  int'(m_refv));
`ifdef SLICER_ERR_EN
            check("err_out",    int'(bus.err_out),    m_err);
`endif
        end
    end

    task automatic drive(bit en, int x, bit r);
        @(negedge clk);
        bus.sym_en    = en;
        bus.slicer_in = 18'(x);
        reset         = r;
    endtask

    // One sample, literal decision check, then an idle cycle checking hold.
    task automatic sym_chk(int x, int exp_out, string nm);
        drive(1'b1, x, 1'b0);
        @(posedge clk); #1;
        check({nm, "_out"}, int'(bus.slicer_out), exp_out);
        check({nm, "_vld"}, int'(bus.out_valid), 1);
        drive(1'b0, 0, 1'b0);
        @(posedge clk); #1;
        check({nm, "_gap"}, int'(bus.out_valid), 0);
        check({nm, "_hold"}, int'(bus.slicer_out), exp_out);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  x;
        bit  en;
        bit  r;
        bit  tiny;
        bus.sym_en    = 1'b0;
        bus.slicer_in = '0;
        reset         = 1'b1;

        // Reset state
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0);
        @(posedge clk); #1;
        check("rst_ref",   int'(bus.ref_level), 32768);
        check("rst_refv",  int'(bus.ref_valid), 0);
        check("rst_out",   int'(bus.slicer_out), 0);
        check("rst_valid", int'(bus.out_valid), 0);

        // Basic thresholds at ref = 32768
        sym_chk(40000,  3, "thr_40000");
        sym_chk(0,      2, "thr_0");
        sym_chk(-1,     1, "thr_m1");
        sym_chk(-32768, 1, "thr_m32768");
        sym_chk(-40000, 0, "thr_m40000");

`ifdef SLICER_ERR_EN
        drive(1'b0, 0, 1'b1);
        sym_chk(40000, 3, "err_a");
        check("err_40000", int'(bus.err_out), -9152);
        sym_chk(-16384, 1, "err_b");
        check("err_m16384", int'(bus.err_out), 0);
        sym_chk(131071, 3, "err_c");
        check("err_131071", int'(bus.err_out), 81919);
`endif

        // Window of four updates the level; sample after the update uses it
        drive(1'b0, 0, 1'b1);
        sym_chk(60000,  3, "win_a");
        sym_chk(20000,  2, "win_b");
        sym_chk(-20000, 1, "win_c");
        check("win_refv_pre", int'(bus.ref_valid), 0);
        sym_chk(-60000, 0, "win_d");
        check("win_ref",  int'(bus.ref_level), 40000);
        check("win_refv", int'(bus.ref_valid), 1);
        sym_chk(30000,  2, "win_after");

        // Partial window dropped by reset (reset wins over sym_en)
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0);
        sym_chk(10000, 2, "abort_a");
        sym_chk(10000, 2, "abort_b");
        drive(1'b1, 5, 1'b1);
        drive(1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) sym_chk(60000, 3, "abort_win");
        check("abort_ref",  int'(bus.ref_level), 60000);
        check("abort_refv", int'(bus.ref_valid), 1);

        // Back-to-back most-negative samples
        drive(1'b0, 0, 1'b1);
        drive(1'b1, -131072, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("sat_ref4",  int'(bus.ref_level), 131071);
        check("sat_out4",  int'(bus.slicer_out), 0);
        check("sat_vld4",  int'(bus.out_valid), 1);
        repeat (12) @(posedge clk);
        drive(1'b0, 0, 1'b0);
        @(posedge clk); #1;
        check("sat_ref16", int'(bus.ref_level), 131071);
        check("sat_refv",  int'(bus.ref_valid), 1);

        // Randomized traffic
        drive(1'b0, 0, 1'b1);
        tiny = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 64) == 0) tiny = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 9) < 7);
            if (tiny) begin
                x = int'($urandom_range(0, 2)) - 1;
            end else begin
                case ($urandom_range(0, 4))
                    0:       x = int'($urandom_range(0, 262143)) - 131072;
                    1:       x = m_ref + int'($urandom_range(0, 2)) - 1;
                    2:       x = -m_ref + int'($urandom_range(0, 2)) - 1;
                    3:       x = ($urandom_range(0, 1) == 0) ? -131072 : 131071;
                    default: x = int'($urandom_range(0, 80000)) - 40000;
                endcase
            end
            if (x > 131071)  x = 131071;
            if (x < -131072) x = -131072;
            drive(en, x, r);
        end
        drive(1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
